g_sensor_int_service: RTL and testbench
=======================================

# g_sensor_int_service

Avalon-MM master sequencer for the one-bit accelerometer interrupt PIO (edge-capture, registered readdata, 1-cycle read latency). After reset it arms the PIO interrupt mask, waits for the PIO irq, reads and clears the edge-capture register, samples the pin level, and pushes a timestamped event into a small FIFO. The Nios II software or a downstream hardware consumer drains that FIFO instead of servicing the PIO itself.

## Interface
- TS_W, 32: timestamp counter width (8..32).
- FIFO_DEPTH, 8: event FIFO depth, power of 2, 2..64.
- HOLDOFF_CYCLES, 16: minimum idle cycles after each serviced event. 0 disables holdoff.

- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  when 1, new interrupts are accepted in IDLE.
- irq_in  in  1  PIO irq.
- m_address  out  2  PIO register address.
- m_chipselect  out  1  PIO select.
- m_write_n  out  1  active-low write strobe.
- m_writedata  out  32  PIO write data.
- m_readdata  in  32  PIO registered readdata. Only bit 0 is used.
- evt_valid  out  1  FIFO non-empty.
- evt_ready  in  1  consumer accepts the head entry.
- evt_data  out  TS_W+1  {level, timestamp} of the head entry.
- overflow_cnt  out  16  events dropped on full FIFO; saturates at 0xFFFF.
- busy  out  1  1 in every state except IDLE.

## Operation
- Idle bus value, in every state not listed below: m_chipselect=0, m_write_n=1, m_address=0, m_writedata=0.
- ts_cnt:
  - Free-running TS_W-bit counter; wraps from all-ones to 0.
  - Cleared by reset.
- FSM states, one cycle each unless noted:
  - INIT: write 0x1 to address 2 (cs=1, write_n=0). Next state IDLE.
  - IDLE: if irq_in && enable, latch ts_cnt into ts_lat and go to RDCAP. Otherwise stay.
  - RDCAP: read address 3 (cs=1, write_n=1). Next state CAPW.
  - CAPW: sample m_readdata[0].
    - If 1, go to CLR.
    - If 0 (spurious), go to IDLE with no push.
  - CLR: write 0x0 to address 3. Next state RDDAT.
  - RDDAT: read address 0. Next state DATW.
  - DATW: latch level = m_readdata[0]. Next state PUSH.
  - PUSH: write {level, ts_lat} to the FIFO.
    - Next state HOLD if HOLDOFF_CYCLES>0, otherwise IDLE.
  - HOLD: stay exactly HOLDOFF_CYCLES cycles, then go to IDLE. irq_in is ignored.
- Edges arriving during service (after CLR) are re-captured by the PIO. irq_in is then high again on return to IDLE and is serviced normally.
- enable is sampled only in IDLE. Deasserting enable mid-service does not abort the sequence. A pending irq stays pending while enable=0.
- FIFO:
  - Show-ahead: evt_data = head entry whenever evt_valid=1.
  - Pop when evt_valid && evt_ready.
  - Push in PUSH succeeds if not full, or if full and a pop occurs in the same cycle.
  - Otherwise the push is dropped and overflow_cnt increments, saturating.
  - Simultaneous push and pop on a non-empty FIFO: count unchanged.
- Reset, including mid-operation:
  - FSM goes to INIT; FIFO empties; overflow_cnt, ts_cnt and ts_lat clear; bus returns to idle value.
  - The INIT mask write is re-issued in the first cycle after reset deasserts.

## Timing
- Reset values: m_chipselect=0, m_write_n=1, m_address=0, m_writedata=0, evt_valid=0, evt_data=0, overflow_cnt=0, busy=0.
- All master outputs are registered and change only on clk edges.
- Read protocol: address is driven in cycle N; m_readdata is sampled in cycle N+1, matching the PIO's registered read.
- Write protocol: single-cycle cs && !write_n. No wait states.
- Latency, with irq_in sampled high in IDLE at cycle T:
  - T+1 RDCAP, T+2 CAPW, T+3 CLR, T+4 RDDAT, T+5 DATW, T+6 PUSH.
  - evt_valid rises at T+7 if the FIFO was empty.
  - The PIO irq drops at T+4.
- Timestamp is ts_cnt at cycle T, not at PUSH.
- Service period without holdoff: 7 cycles IDLE-to-IDLE. With holdoff: 7 + HOLDOFF_CYCLES.
- busy is 0 only in IDLE. It is 1 during INIT after reset.

## Test plan
- Reset release with the PIO model attached:
  - First bus cycle writes 0x1 to address 2.
  - busy is 1 for one cycle, then 0.
  - evt_valid=0 and overflow_cnt=0.
- Single rising edge on in_port with ts_cnt=0x100 at detection:
  - Bus sequence is RD3, WR3=0, RD0.
  - evt_data={1,0x100} with evt_valid at T+7.
  - irq low from T+4.
- Spurious irq_in forced high while PIO edge_capture=0:
  - Reads address 3 only, then returns to IDLE.
  - No FIFO push and no write issued.
- FIFO_DEPTH=8, evt_ready=0, 10 edges spaced by 40 cycles:
  - Exactly 8 entries in FIFO, overflow_cnt=2.
  - Timestamps drained in arrival order.
  - Push-while-full with evt_ready=1 in the same cycle is accepted and overflow_cnt is unchanged.
- HOLDOFF_CYCLES=16, second edge 3 cycles after the first PUSH:
  - Second event is serviced at IDLE+16, not earlier.
  - Its timestamp equals ts_cnt at that IDLE cycle.
- Reset asserted in CLR with 3 entries queued:
  - FIFO empties and evt_valid=0 next cycle.
  - INIT write is reissued.
  - The still-set PIO edge_capture is then serviced normally; one event results.

Source files
------------

// File: rtl/g_sensor_int_service.sv
// g_sensor_int_service
// Avalon-MM master sequencer servicing a one-bit accelerometer interrupt PIO.
// After reset it writes the PIO interrupt mask. It then waits for irq_in and
// reads and clears the edge-capture register. It samples the pin level and
// pushes a {level, timestamp} event into a show-ahead FIFO for a consumer.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   enable              accept new interrupts while idle
//   irq_in              PIO interrupt request
//   m_address .. m_readdata   Avalon-MM master to the PIO (registered
//                             readdata, 1-cycle read latency, bit 0 used)
//   evt_valid/evt_ready/evt_data   event FIFO head, {level, timestamp}
//   overflow_cnt        events dropped on a full FIFO, saturating
//   busy                high whenever the sequencer is not idle
module g_sensor_int_service #(
    parameter int TS_W           = 32,
    parameter int FIFO_DEPTH     = 8,
    parameter int HOLDOFF_CYCLES = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic            irq_in,
    output logic [1:0]      m_address,
    output logic            m_chipselect,
    output logic            m_write_n,
    output logic [31:0]     m_writedata,
    input  logic [31:0]     m_readdata,
    output logic            evt_valid,
    input  logic            evt_ready,
    output logic [TS_W:0]   evt_data,
    output logic [15:0]     overflow_cnt,
    output logic            busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

    typedef enum logic [3:0] {
        ST_INIT, ST_IDLE, ST_RDCAP, ST_CAPW, ST_CLR,
        ST_RDDAT, ST_DATW, ST_PUSH, ST_HOLD
    } state_t;

    state_t          state_q, state_d;
    logic [TS_W-1:0] ts_cnt, ts_lat;
    logic            level_q;
    logic [HW-1:0]   hold_cnt;

    logic            cs_d, wn_d, busy_d;
    logic [1:0]      addr_d;
    logic [31:0]     wd_d;

    logic [TS_W:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;
    logic            push_req, push_ok, pop, full;

    logic            unused_rd;
    assign unused_rd = ^m_readdata[31:1];

    // Next state, plus the bus value for that state so the master outputs
    // can be loaded straight into registers.
    always_comb begin
        state_d = state_q;
        case (state_q)
            // The state register enters INIT on reset while the bus registers
            // are held idle; stay one more cycle so the mask write is driven.
            ST_INIT:  if (m_chipselect) state_d = ST_IDLE;
            ST_IDLE:  if (irq_in && enable) state_d = ST_RDCAP;
            ST_RDCAP: state_d = ST_CAPW;
            ST_CAPW:  state_d = m_readdata[0] ? ST_CLR : ST_IDLE;
            ST_CLR:   state_d = ST_RDDAT;
            ST_RDDAT: state_d = ST_DATW;
            ST_DATW:  state_d = ST_PUSH;
            ST_PUSH:  state_d = (HOLDOFF_CYCLES > 0) ? ST_HOLD : ST_IDLE;
            ST_HOLD:  if (hold_cnt == '0) state_d = ST_IDLE;
            default:  state_d = ST_INIT;
        endcase

        cs_d   = 1'b0;
        wn_d   = 1'b1;
        addr_d = 2'd0;
        wd_d   = '0;
        busy_d = (state_d != ST_IDLE);
        case (state_d)
            ST_INIT: begin
                cs_d   = 1'b1;
                wn_d   = 1'b0;
                addr_d = 2'd2;
                wd_d   = 32'd1;
            end
            ST_RDCAP: begin
                cs_d   = 1'b1;
                addr_d = 2'd3;
            end
            ST_CLR: begin
                cs_d   = 1'b1;
                wn_d   = 1'b0;
                addr_d = 2'd3;
            end
            ST_RDDAT: begin
                cs_d   = 1'b1;
                addr_d = 2'd0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_INIT;
            m_chipselect <= 1'b0;
            m_write_n    <= 1'b1;
            m_address    <= 2'd0;
            m_writedata  <= '0;
            busy         <= 1'b0;
            ts_cnt       <= '0;
            ts_lat       <= '0;
            level_q      <= 1'b0;
            hold_cnt     <= '0;
        end else begin
            state_q      <= state_d;
            m_chipselect <= cs_d;
            m_write_n    <= wn_d;
            m_address    <= addr_d;
            m_writedata  <= wd_d;
            busy         <= busy_d;
            ts_cnt       <= ts_cnt + 1'b1;
            if (state_q == ST_IDLE && state_d == ST_RDCAP)
                ts_lat <= ts_cnt;
            if (state_q == ST_DATW)
                level_q <= m_readdata[0];
            if (state_q == ST_PUSH)
                hold_cnt <= HOLD_LOAD;
            else if (state_q == ST_HOLD)
                hold_cnt <= hold_cnt - 1'b1;
        end
    end

    // Show-ahead event FIFO. A push into a full FIFO is accepted when the
    // head is popped in the same cycle.
    assign evt_valid = (count != '0);
    assign pop       = evt_valid && evt_ready;
    assign full      = (count == FULL_CNT);
    assign push_req  = (state_q == ST_PUSH);
    assign push_ok   = push_req && (!full || pop);
    assign evt_data  = evt_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= {level_q, ts_lat};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            overflow_cnt <= '0;
        end else begin
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (push_req && !push_ok && overflow_cnt != 16'hFFFF)
                overflow_cnt <= overflow_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_g_sensor_int_service.sv
// Bench for g_sensor_int_service: a PIO model (edge capture, mask, registered
// readdata), a latency-table model of the expected outputs compared every
// cycle, and directed scenarios with literal expectations.
module tb_g_sensor_int_service;
    localparam int TS_W  = 32;
    localparam int DEPTH = 8;
    localparam int HOLD  = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b1;
    logic          irq_in;
    logic [1:0]    m_address;
    logic          m_chipselect;
    logic          m_write_n;
    logic [31:0]   m_writedata;
    logic [31:0]   m_readdata = '0;
    logic          evt_valid;
    logic          evt_ready = 1'b0;
    logic [TS_W:0] evt_data;
    logic [15:0]   overflow_cnt;
    logic          busy;

    always #5 clk = ~clk;

    g_sensor_int_service #(
        .TS_W(TS_W),
        .FIFO_DEPTH(DEPTH),
        .HOLDOFF_CYCLES(HOLD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .irq_in(irq_in),
        .m_address(m_address),
        .m_chipselect(m_chipselect),
        .m_write_n(m_write_n),
        .m_writedata(m_writedata),
        .m_readdata(m_readdata),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_data(evt_data),
        .overflow_cnt(overflow_cnt),
        .busy(busy)
    );

    // PIO slave model
    logic in_port = 1'b0, in_q = 1'b0, pio_mask = 1'b0, pio_cap = 1'b0, irq_force = 1'b0;
    always @(posedge clk) begin
        in_q <= in_port;
        if (m_chipselect && !m_write_n && m_address == 2'd2)
            pio_mask <= m_writedata[0];
        if (in_port && !in_q)
            pio_cap <= 1'b1;
        else if (m_chipselect && !m_write_n && m_address == 2'd3)
            pio_cap <= 1'b0;
        case (m_address)
            2'd0:    m_readdata <= {31'b0, in_port};
            2'd2:    m_readdata <= {31'b0, pio_mask};
            2'd3:    m_readdata <= {31'b0, pio_cap};
            default: m_readdata <= '0;
        endcase
    end
    assign irq_in = (pio_cap & pio_mask) | irq_force;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Expected-behaviour model: service is a table of offsets from the
    // detection cycle T (bus op per offset, push at T+6, idle at T+7+HOLD).
    typedef enum {M_RST, M_INIT, M_IDLE, M_SVC} mstate_t;
    mstate_t        ms = M_RST;
    bit             mvalid = 1'b0;
    int             off = 0;
    logic [31:0]    mts = '0;
    logic [31:0]    tsl = '0;
    logic           lvl = 1'b0;
    logic [TS_W:0]  mq[$];
    logic [15:0]    movf = '0;

    always @(negedge clk) begin
        logic        e_cs, e_wn, e_busy, e_valid, pop, push, full;
        logic [1:0]  e_a;
        logic [31:0] e_wd;
        logic [TS_W:0] e_data;
        if (mvalid) begin
            e_cs = 1'b0; e_wn = 1'b1; e_a = 2'd0; e_wd = '0; e_busy = 1'b1;
            case (ms)
                M_RST:  e_busy = 1'b0;
                M_INIT: begin e_cs = 1'b1; e_wn = 1'b0; e_a = 2'd2; e_wd = 32'd1; end
                M_IDLE: e_busy = 1'b0;
                default: begin
                    if (off == 1) begin e_cs = 1'b1; e_a = 2'd3; end
                    if (off == 3) begin e_cs = 1'b1; e_wn = 1'b0; e_a = 2'd3; end
                    if (off == 4) begin e_cs = 1'b1; e_a = 2'd0; end
                end
            endcase
            e_valid = (mq.size() != 0);
            e_data  = e_valid ? mq[0] : '0;
            check("cycle",
                  {m_chipselect, m_write_n, m_address, m_writedata, busy, evt_valid, evt_data, overflow_cnt},
                  {e_cs, e_wn, e_a, e_wd, e_busy, e_valid, e_data, movf});
        end
        if (reset) begin
            mvalid = 1'b1;
            ms = M_RST;
            mq.delete();
            movf = '0;
            mts = '0;
            off = 0;
        end else if (mvalid) begin
            pop  = (mq.size() != 0) && evt_ready;
            push = 1'b0;
            case (ms)
                M_RST:  ms = M_INIT;
                M_INIT: ms = M_IDLE;
                M_IDLE: if (irq_in && enable) begin tsl = mts; off = 1; ms = M_SVC; end
                default: begin
                    if (off == 2 && !m_readdata[0]) ms = M_IDLE;
                    else begin
                        if (off == 5) lvl = m_readdata[0];
                        if (off == 6) push = 1'b1;
                        if (off == 6 + HOLD) ms = M_IDLE;
                        else off++;
                    end
                end
            endcase
            full = (mq.size() == DEPTH);
            if (pop) void'(mq.pop_front());
            if (push) begin
                if (!full || pop) mq.push_back({lvl, tsl});
                else if (movf != 16'hFFFF) movf++;
            end
            mts = mts + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [TS_W:0] exp_q[$];
    logic [31:0]   r, r1;

    initial begin
        repeat (3) tick();
        check("reset_vals",
              {m_chipselect, m_write_n, m_address, m_writedata, busy, evt_valid, evt_data, overflow_cnt},
              {1'b0, 1'b1, 2'd0, 32'd0, 1'b0, 1'b0, 33'd0, 16'd0});
        reset = 1'b0;
        tick();
        check("init_write", {m_chipselect, m_write_n, m_address, m_writedata, busy},
              {1'b1, 1'b0, 2'd2, 32'd1, 1'b1});
        tick();
        check("init_busy_drop", {busy, m_chipselect, evt_valid, overflow_cnt}, 0);

        // single edge detected with ts_cnt = 0x100
        while (mts != 32'hFF) tick();
        in_port = 1'b1;
        tick();                                   // T
        tick();                                   // T+1
        check("rdcap_bus", {m_chipselect, m_write_n, m_address}, {1'b1, 1'b1, 2'd3});
        tick(); tick();                           // T+3
        check("clr_bus", {m_chipselect, m_write_n, m_address, m_writedata, irq_in},
              {1'b1, 1'b0, 2'd3, 32'd0, 1'b1});
        tick();                                   // T+4
        check("rddat_bus_irq_low", {m_chipselect, m_write_n, m_address, irq_in},
              {1'b1, 1'b1, 2'd0, 1'b0});
        tick(); tick();                           // T+6
        check("valid_before_t7", evt_valid, 1'b0);
        tick();                                   // T+7
        check("first_event", {evt_valid, evt_data}, {1'b1, 33'h1_0000_0100});
        in_port = 1'b0;
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        repeat (25) tick();

        // spurious irq with edge_capture clear
        irq_force = 1'b1;
        tick();
        irq_force = 1'b0;
        check("spurious_rd3", {m_chipselect, m_write_n, m_address}, {1'b1, 1'b1, 2'd3});
        tick(); tick();
        check("spurious_back_idle", {busy, m_chipselect, evt_valid}, 3'b000);
        repeat (10) tick();

        // overflow: 10 edges, no consumer
        for (int i = 0; i < 10; i++) begin
            int hi;
            hi = (i % 2 == 0) ? 10 : 3;
            in_port = 1'b1;
            r = mts + 1;
            if (i < DEPTH) exp_q.push_back({(i % 2 == 0) ? 1'b1 : 1'b0, r});
            repeat (hi) tick();
            in_port = 1'b0;
            repeat (40 - hi) tick();
        end
        check("overflow_two", {evt_valid, overflow_cnt}, {1'b1, 16'd2});

        // push into full FIFO with a pop in the same cycle
        in_port = 1'b1;
        r = mts + 1;
        repeat (7) tick();                        // PUSH cycle
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back({1'b1, r});
        repeat (2) tick();
        in_port = 1'b0;
        repeat (30) tick();
        check("full_push_pop_ovf", overflow_cnt, 16'd2);
        evt_ready = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            check($sformatf("drain%0d", k), {evt_valid, evt_data}, {1'b1, exp_q[k]});
            tick();
        end
        evt_ready = 1'b0;
        check("drained_empty", evt_valid, 1'b0);
        exp_q.delete();
        repeat (5) tick();

        // holdoff: second edge 3 cycles after the first PUSH
        in_port = 1'b1;                           // X
        r1 = mts + 1;
        repeat (6) tick();
        in_port = 1'b0;
        repeat (4) tick();
        in_port = 1'b1;                           // X+10
        repeat (13) tick();                       // X+23, last HOLD cycle
        check("holdoff_still_busy", {busy, irq_in}, 2'b11);
        tick();
        check("holdoff_idle", busy, 1'b0);
        tick();
        check("holdoff_rdcap", {m_chipselect, m_write_n, m_address}, {1'b1, 1'b1, 2'd3});
        repeat (30) tick();
        in_port = 1'b0;
        evt_ready = 1'b1;
        check("holdoff_ev0", {evt_valid, evt_data}, {1'b1, 1'b1, r1});
        tick();
        check("holdoff_ev1", {evt_valid, evt_data}, {1'b1, 1'b1, r1 + 32'd23});
        tick();
        evt_ready = 1'b0;
        check("holdoff_empty", evt_valid, 1'b0);
        repeat (5) tick();

        // reset landing on the CLR edge with 3 entries queued
        for (int i = 0; i < 3; i++) begin
            in_port = 1'b1;
            repeat (10) tick();
            in_port = 1'b0;
            repeat (30) tick();
        end
        in_port = 1'b1;                           // X
        repeat (3) tick();                        // X+3, CAPW
        check("queued_before_reset", evt_valid, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("reset_flush", {evt_valid, overflow_cnt, m_chipselect, busy}, 0);
        tick();
        check("reinit_write", {m_chipselect, m_write_n, m_address, m_writedata},
              {1'b1, 1'b0, 2'd2, 32'd1});
        tick();
        check("pending_irq", irq_in, 1'b1);
        repeat (7) tick();
        check("post_reset_event", {evt_valid, evt_data, overflow_cnt},
              {1'b1, 33'h1_0000_0002, 16'd0});
        in_port = 1'b0;
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        repeat (25) tick();
        check("single_event_only", {evt_valid, overflow_cnt}, 0);

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1);
    end

endmodule
